// File: rtl/hm_result_reader.sv
// Buffers {hash,nonce} results captured on the flag's rising edge and streams them out word by word, byte order restored.
// First word valid 2 cycles after capture; word_ready=0 holds the word; a push into a full FIFO is dropped (sticky overflow).
module hm_result_reader #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_WORDS  = 9,
  parameter int DEPTH      = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WORD_WIDTH*NUM_WORDS-1:0] valid_hash,
  input  logic                            valid_hash_flag,
  input  logic                            clear,
  output logic [WORD_WIDTH-1:0]           word_out,
  output logic                            word_valid,
  input  logic                            word_ready,
  output logic                            word_last,
  output logic [3:0]                      word_index,
  output logic                            overflow,
  output logic                            empty
);

  localparam int BUS_W = WORD_WIDTH * NUM_WORDS;
  localparam int NB    = WORD_WIDTH / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [3:0] LAST = 4'(NUM_WORDS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state_q;
  logic               valid_q;
  logic [3:0]         idx_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               flag_q;
  logic               overflow_q;
  logic [BUS_W-1:0]   mem_q [DEPTH];

  logic push, full, hs, pop, push_acc, drop;
  logic [WORD_WIDTH-1:0] head_word, word_swap;

  assign push     = valid_hash_flag & ~flag_q;
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign hs       = valid_q & word_ready;
  assign pop      = hs & (idx_q == LAST);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_acc = push & (~full | pop);
  assign drop     = push & full & ~pop;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_acc, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      flag_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      flag_q <= valid_hash_flag;
      if (clear) begin
        state_q    <= IDLE;
        valid_q    <= 1'b0;
        idx_q      <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        cnt_q      <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push_acc) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)      rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (drop)     overflow_q <= 1'b1;
        cnt_q <= cnt_d;
        case (state_q)
          IDLE: begin
            if (cnt_q != '0) begin
              state_q <= STREAM;
              valid_q <= 1'b1;
            end
          end
          STREAM: begin
            if (hs) begin
              if (idx_q == LAST) begin
                idx_q <= '0;
                // cnt_d already counts a push landing in this same cycle.
                if (cnt_d == '0) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
                end
              end else begin
                idx_q <= idx_q + 4'd1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc && !clear) mem_q[wr_ptr_q] <= valid_hash;
  end

  always_comb begin
    head_word = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (idx_q == 4'(k)) head_word = mem_q[rd_ptr_q][k*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  always_comb begin
    word_swap = '0;
    for (int b = 0; b < NB; b++) begin
      word_swap[b*8 +: 8] = head_word[(NB-1-b)*8 +: 8];
    end
  end

  assign word_valid = valid_q;
  assign word_out   = valid_q ? word_swap : '0;
  assign word_last  = valid_q & (idx_q == LAST);
  assign word_index = idx_q;
  assign overflow   = overflow_q;
  assign empty      = (cnt_q == '0);

endmodule

// File: tb/tb_hm_result_reader.sv
// Scoreboard bench for hm_result_reader: expected words queued at each flag edge, checked on every handshake.
module tb_hm_result_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic [287:0] valid_hash;
  logic         valid_hash_flag;
  logic         clear;
  logic [31:0]  word_out;
  logic         word_valid;
  logic         word_ready;
  logic         word_last;
  logic [3:0]   word_index;
  logic         overflow;
  logic         empty;

  int checks   = 0;
  int failures = 0;

  logic [35:0] exp_q[$];
  logic [31:0] nat[9];
  bit          mon_en = 1'b0;

  logic        stall_prev = 1'b0;
  logic        last_prev  = 1'b0;
  logic [31:0] prev_word;
  logic [3:0]  prev_idx;
  logic [35:0] e;

  hm_result_reader #(.WORD_WIDTH(32), .NUM_WORDS(9), .DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_hash      (valid_hash),
    .valid_hash_flag (valid_hash_flag),
    .clear           (clear),
    .word_out        (word_out),
    .word_valid      (word_valid),
    .word_ready      (word_ready),
    .word_last       (word_last),
    .word_index      (word_index),
    .overflow        (overflow),
    .empty           (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bus words carry each native word with its bytes reversed.
  task automatic load_bus();
    for (int k = 0; k < 9; k++)
      valid_hash[32*k +: 32] = {nat[k][7:0], nat[k][15:8], nat[k][23:16], nat[k][31:24]};
  endtask

  task automatic rand_nat(input logic [31:0] nonce);
    nat[0] = nonce;
    for (int k = 1; k < 9; k++) nat[k] = $urandom;
    load_bus();
  endtask

  task automatic expect_result();
    for (int k = 0; k < 9; k++) exp_q.push_back({4'(k), nat[k]});
  endtask

  task automatic pulse(input int hold, input bit accept);
    valid_hash_flag = 1'b1;
    if (accept) expect_result();
    repeat (hold) begin
      @(posedge clk); #1;
    end
    valid_hash_flag = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain(input bit bp);
    int c;
    for (c = 0; c < 300; c++) begin
      if (exp_q.size() == 0 && !word_valid) break;
      word_ready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      @(posedge clk); #1;
    end
    word_ready = 1'b1;
    check("drain_timeout", 64'(c < 300), 64'(1));
    check("empty_after", 64'(empty), 64'(1));
  endtask

  task automatic wait_idx4(output bit found);
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (word_valid && word_index == 4'd4) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("idx4_reached", 64'(found), 64'(1));
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      stall_prev = 1'b0;
      last_prev  = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_vld", 64'(word_valid), 64'(1));
        check("stall_dat", 64'(word_out), 64'(prev_word));
        check("stall_idx", 64'(word_index), 64'(prev_idx));
      end
      if (last_prev) check("b2b_vld", 64'(word_valid), 64'(1));
      last_prev = 1'b0;
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 64'(word_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("word_dat", 64'(word_out), 64'(e[31:0]));
          check("word_idx", 64'(word_index), 64'(e[35:32]));
          check("word_last", 64'(word_last), 64'(e[35:32] == 4'd8));
          last_prev = (e[35:32] == 4'd8) && (exp_q.size() > 0);
        end
      end
      stall_prev = word_valid && !word_ready;
      prev_word  = word_out;
      prev_idx   = word_index;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1;
    valid_hash = '0;
    valid_hash_flag = 1'b0;
    clear = 1'b0;
    word_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", 64'(word_valid), 64'(0));
    check("rst_last", 64'(word_last), 64'(0));
    check("rst_idx", 64'(word_index), 64'(0));
    check("rst_empty", 64'(empty), 64'(1));
    check("rst_out", 64'(word_out), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Single result with fixed, hand-computed words.
    word_ready = 1'b1;
    valid_hash[31:0] = 32'h78563412;
    for (int k = 1; k < 9; k++) valid_hash[32*k +: 32] = 32'(k);
    nat[0] = 32'h12345678;
    for (int k = 1; k < 9; k++) nat[k] = 32'(k) << 24;
    valid_hash_flag = 1'b1;
    expect_result();
    @(posedge clk); #1;
    valid_hash_flag = 1'b0;
    check("lat1_vld", 64'(word_valid), 64'(0));
    @(posedge clk); #1;
    check("lat2_vld", 64'(word_valid), 64'(1));
    check("lat2_dat", 64'(word_out), 64'(32'h12345678));
    drain(1'b0);

    // Flag held high for 5 cycles captures once.
    rand_nat(32'hAAAA0001);
    pulse(5, 1'b1);
    drain(1'b0);

    // Backpressure 1,0,0,1.
    rand_nat(32'hBBBB0001);
    pulse(1, 1'b1);
    drain(1'b1);

    // Overflow: third result dropped, first two back-to-back.
    word_ready = 1'b0;
    rand_nat(32'hA0A0A0A0); pulse(1, 1'b1);
    rand_nat(32'hB0B0B0B0); pulse(1, 1'b1);
    rand_nat(32'hC0C0C0C0); pulse(1, 1'b0);
    check("ovf_set", 64'(overflow), 64'(1));
    check("ovf_not_empty", 64'(empty), 64'(0));
    drain(1'b0);
    check("ovf_sticky", 64'(overflow), 64'(1));
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("ovf_cleared", 64'(overflow), 64'(0));

    // Full FIFO plus push coinciding with the word-8 handshake.
    word_ready = 1'b0;
    rand_nat(32'h11110001); pulse(1, 1'b1);
    rand_nat(32'h22220002); pulse(1, 1'b1);
    word_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (word_valid && word_index == 4'd8) begin
        found = 1'b1;
        break;
      end
    end
    check("fp_found", 64'(found), 64'(1));
    if (found) begin
      rand_nat(32'h33330003);
      valid_hash_flag = 1'b1;
      expect_result();
      @(posedge clk); #1;
      valid_hash_flag = 1'b0;
    end
    drain(1'b0);
    check("fp_ovf", 64'(overflow), 64'(0));

    // clear mid-stream at idx 4 with one result queued and overflow set.
    word_ready = 1'b0;
    rand_nat(32'h44440004); pulse(1, 1'b1);
    rand_nat(32'h55550005); pulse(1, 1'b1);
    rand_nat(32'h66660006); pulse(1, 1'b0);
    check("clr_ovf_pre", 64'(overflow), 64'(1));
    word_ready = 1'b1;
    wait_idx4(found);
    mon_en = 1'b0;
    word_ready = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_vld", 64'(word_valid), 64'(0));
    check("clr_empty", 64'(empty), 64'(1));
    check("clr_ovf", 64'(overflow), 64'(0));
    exp_q.delete();
    @(posedge clk); #1;
    check("clr_vld_hold", 64'(word_valid), 64'(0));
    mon_en = 1'b1;

    // Asynchronous rst mid-stream.
    rand_nat(32'h77770007); pulse(1, 1'b1);
    rand_nat(32'h88880008); pulse(1, 1'b1);
    word_ready = 1'b1;
    wait_idx4(found);
    mon_en = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("arst_vld", 64'(word_valid), 64'(0));
    check("arst_idx", 64'(word_index), 64'(0));
    check("arst_last", 64'(word_last), 64'(0));
    check("arst_out", 64'(word_out), 64'(0));
    check("arst_empty", 64'(empty), 64'(1));
    @(posedge clk); #2;
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    mon_en = 1'b1;
    check("arst_empty_after", 64'(empty), 64'(1));

    // Recovery after reset.
    rand_nat(32'h99990009);
    pulse(1, 1'b1);
    drain(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
